// File: rtl/pisa_kbd_pkg.sv
// Shared PS/2 set-2 scancode constants, controller state type and key-map helpers.
package pisa_kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Command keys
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Hex digit keys
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2,
    ST_BUSY  = 2'd3
  } qsel_state_t;

  // Map a make code to {valid, hex index}.
  function automatic logic [4:0] sc_to_hex(input logic [7:0] sc);
    case (sc)
      SC_0:    sc_to_hex = {1'b1, 4'h0};
      SC_1:    sc_to_hex = {1'b1, 4'h1};
      SC_2:    sc_to_hex = {1'b1, 4'h2};
      SC_3:    sc_to_hex = {1'b1, 4'h3};
      SC_4:    sc_to_hex = {1'b1, 4'h4};
      SC_5:    sc_to_hex = {1'b1, 4'h5};
      SC_6:    sc_to_hex = {1'b1, 4'h6};
      SC_7:    sc_to_hex = {1'b1, 4'h7};
      SC_8:    sc_to_hex = {1'b1, 4'h8};
      SC_9:    sc_to_hex = {1'b1, 4'h9};
      SC_A:    sc_to_hex = {1'b1, 4'hA};
      SC_B:    sc_to_hex = {1'b1, 4'hB};
      SC_C:    sc_to_hex = {1'b1, 4'hC};
      SC_D:    sc_to_hex = {1'b1, 4'hD};
      SC_E:    sc_to_hex = {1'b1, 4'hE};
      SC_F:    sc_to_hex = {1'b1, 4'hF};
      default: sc_to_hex = 5'd0;
    endcase
  endfunction

  // One-hot LED pattern for a quadrant index.
  function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
    idx_to_onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/scancode_decoder.sv
// Tracks F0/E0 prefixes and turns completed make codes into one-cycle key strobes.
module scancode_decoder
  import pisa_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_byte,
  output logic       key_make,
  output logic       key_hex_valid,
  output logic [3:0] key_idx,
  output logic       key_enter,
  output logic       key_esc
);

  logic       brk;
  logic       ext;
  logic       is_code;
  logic       act;
  logic [4:0] hex;

  // Decode the current byte against the prefix flags; strobes are valid in the scan_valid cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    is_code       = scan_valid && (scan_byte != SC_BRK) && (scan_byte != SC_EXT);
    hex           = sc_to_hex(scan_byte);
    // Releases are ignored; extended codes only matter for keypad Enter.
    act           = is_code && !brk && (!ext || (scan_byte == SC_ENTER));
    key_hex_valid = act && hex[4];
    key_idx       = hex[3:0];
    key_enter     = act && (scan_byte == SC_ENTER);
    key_esc       = act && (scan_byte == SC_ESC);
    key_make      = key_hex_valid || key_enter || key_esc;
  end

  // Prefix flags: set by F0/E0, cleared once any other byte consumes them.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (scan_valid) begin
      if (scan_byte == SC_BRK) begin
        brk <= 1'b1;
      end else if (scan_byte == SC_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/quadrant_select_ctrl.sv
// Keyboard quadrant selector: pending/confirmed quadrant tracking and engine req/ack/done sequencing.
module quadrant_select_ctrl
  import pisa_kbd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_valid,
  input  logic [7:0]  scan_byte,
  output logic        proc_req,
  input  logic        proc_ack,
  input  logic        proc_done,
  output logic [15:0] quad_led,
  output logic [15:0] quad_confirm,
  output logic [7:0]  quad_value,
  output logic        busy,
  output logic        ack_err,
  output logic [7:0]  drop_cnt
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic        key_make;
  logic        key_hex_valid;
  logic [3:0]  key_idx;
  logic        key_enter;
  logic        key_esc;

  qsel_state_t state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0] led_d;
  logic [15:0] confirm_d;
  logic [7:0]  value_d;
  logic        err_d;
  logic [7:0]  drop_d;

  scancode_decoder u_dec (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_valid    (scan_valid),
    .scan_byte     (scan_byte),
    .key_make      (key_make),
    .key_hex_valid (key_hex_valid),
    .key_idx       (key_idx),
    .key_enter     (key_enter),
    .key_esc       (key_esc)
  );

  // Next-state and next-output logic for the selection/handshake FSM.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    timer_d   = timer_q;
    led_d     = quad_led;
    confirm_d = quad_confirm;
    value_d   = quad_value;
    err_d     = ack_err;
    drop_d    = drop_cnt;

    // Keys arriving while the engine owns the selection are counted, not acted on.
    if ((state_q == ST_REQ || state_q == ST_BUSY) && key_make && (drop_cnt != 8'hFF)) begin
      drop_d = drop_cnt + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (key_hex_valid) begin
          pend_d  = key_idx;
          led_d   = idx_to_onehot(key_idx);
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (key_hex_valid) begin
          pend_d = key_idx;
          led_d  = idx_to_onehot(key_idx);
        end else if (key_esc) begin
          led_d   = 16'd0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (key_enter) begin
          confirm_d = idx_to_onehot(pend_q);
          value_d   = {4'd0, pend_q};
          led_d     = 16'd0;
          timer_d   = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack takes priority over a coincident timeout.
        if (proc_ack) begin
          state_d = ST_BUSY;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          pend_d  = quad_value[3:0];
          led_d   = idx_to_onehot(quad_value[3:0]);
          state_d = ST_ARMED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (proc_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; proc_req/busy are decoded from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= 4'd0;
      timer_q      <= '0;
      proc_req     <= 1'b0;
      busy         <= 1'b0;
      quad_led     <= 16'd0;
      quad_confirm <= 16'd0;
      quad_value   <= 8'd0;
      ack_err      <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      timer_q      <= timer_d;
      proc_req     <= (state_d == ST_REQ);
      busy         <= (state_d == ST_REQ) || (state_d == ST_BUSY);
      quad_led     <= led_d;
      quad_confirm <= confirm_d;
      quad_value   <= value_d;
      ack_err      <= err_d;
      drop_cnt     <= drop_d;
    end
  end

endmodule
